// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: ordered {inst, pc, pc+4} entries, NOP presented when empty.
// One-cycle push-to-head latency; in_ready depends only on occupancy; flush and reset clear all entries.

module if_id_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    output logic                     push_rdy,
    input  logic [W-1:0]             push_dat,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   cnt;
    logic          push_fire;
    logic          pop_fire;

    // Ready and valid come from occupancy alone, so neither side ever bypasses the storage.
    assign push_rdy  = (cnt < FULL_CNT);
    assign pop_vld   = (cnt != '0);
    assign push_fire = push_vld && push_rdy && !flush;
    assign pop_fire  = pop_vld && pop_rdy && !flush;
    assign pop_dat   = mem[head];
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push_fire) tail <= tail + AW'(1);
            if (pop_fire)  head <= head + AW'(1);
            case ({push_fire, pop_fire})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (rst_n && push_fire) mem[tail] <= push_dat;
    end
endmodule

module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_pc_plus4,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_pc_plus4,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } entry_t;

    entry_t push_dat;
    entry_t head_dat;
    logic   head_vld;

    assign push_dat = '{inst: in_inst, pc: in_pc, pc_plus4: in_pc_plus4};

    if_id_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (push_dat),
        .pop_vld  (head_vld),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat),
        .count    (count)
    );

    // Decode sees a harmless NOP with zero addresses whenever nothing is queued.
    always_comb begin
        out_valid    = head_vld;
        out_inst     = NOP_INST;
        out_pc       = '0;
        out_pc_plus4 = '0;
        if (head_vld) begin
            out_inst     = head_dat.inst;
            out_pc       = head_dat.pc;
            out_pc_plus4 = head_dat.pc_plus4;
        end
    end
endmodule
